mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mul_1bit.sv | 11 +
 rtl/mux_rr_arbiter.sv | 95 +++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int   CNT_W = 8;

endpackage

// File: rtl/mul_1bit.sv
// One-bit 2:1 select cell: x=0 passes a, x=1 passes b.
module mul_1bit (
  input  logic x,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = x ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered shared data bit.
// Define MUX_ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic data_a,
  input  logic data_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic y,
  output logic busy
);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state, state_n;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic             hold_hit;
  logic             grant_entry;
  logic             mux_out;

  assign hold_hit    = (cnt == CNT_W'(HOLD_MAX - 1));
  assign grant_entry = (state_n != state) && (state_n != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A falling holder hands straight to a waiting peer so the bus never idles.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) state_n = ptr ? GNT_B : GNT_A;
        else if (req_a)     state_n = GNT_A;
        else if (req_b)     state_n = GNT_B;
      end
      GNT_A: begin
        if (!req_a)                             state_n = req_b ? GNT_B : IDLE;
        else if (TIMEOUT_EN && hold_hit && req_b) state_n = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                             state_n = req_a ? GNT_A : IDLE;
        else if (TIMEOUT_EN && hold_hit && req_a) state_n = GNT_A;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_a = (state == GNT_A);
    gnt_b = (state == GNT_B);
    busy  = gnt_a || gnt_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
      sel <= SEL_A;
      cnt <= '0;
    end else begin
      if (grant_entry) ptr <= (state_n == GNT_A);
      if (state_n == GNT_A)      sel <= SEL_A;
      else if (state_n == GNT_B) sel <= SEL_B;
      if (grant_entry)                      cnt <= '0;
      else if (state != IDLE && cnt != '1)  cnt <= cnt + 1'b1;
    end
  end

  mul_1bit u_mux (
    .x (sel),
    .a (data_a),
    .b (data_b),
    .y (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y <= 1'b0;
    else        y <= mux_out;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (default and MUX_ARB_TIMEOUT_EN builds).
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HM = 4;
`else
  localparam int HM = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, data_a = 1'b0, data_b = 1'b0;
  logic gnt_a, gnt_b, sel, y, busy;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  mux_rr_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Grant exclusivity and busy consistency, checked every cycle.
  always @(negedge clk) begin
    total_cnt++;
    if ((gnt_a && gnt_b) || (busy !== (gnt_a || gnt_b)))
      $display("FAIL invariant: gnt_a=%b gnt_b=%b busy=%b", gnt_a, gnt_b, busy);
    else pass_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    req_a = 1'b1; req_b = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_sel",   sel,   1'b0);
    chk("rst_y",     y,     1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("first_gnt_a", gnt_a, 1'b1);
    chk("first_sel",   sel,   1'b0);
    req_a = 1'b0;
    tick();
    chk("handoff_gnt_b", gnt_b, 1'b1);
    chk("handoff_gnt_a", gnt_a, 1'b0);
    chk("handoff_sel",   sel,   1'b1);
  endtask

  // Continues from GNT_B with sel=1.
  task automatic test_datapath();
    data_a = 1'b1; data_b = 1'b0;
    req_b = 1'b0; req_a = 1'b1;
    tick();
    chk("dp_gnt_a",   gnt_a, 1'b1);
    chk("dp_sel_a",   sel,   1'b0);
    chk("dp_y_lag_a", y,     1'b0);
    tick();
    chk("dp_y_a", y, 1'b1);
    req_a = 1'b0;
    tick();
    chk("dp_idle_busy", busy, 1'b0);
    chk("dp_idle_sel",  sel,  1'b0);
    req_b = 1'b1;
    tick();
    chk("dp_gnt_b",   gnt_b, 1'b1);
    chk("dp_sel_b",   sel,   1'b1);
    chk("dp_y_lag_b", y,     1'b1);
    tick();
    chk("dp_y_b", y, 1'b0);
    req_b = 1'b0;
    tick();
    chk("dp_back_idle", busy, 1'b0);
  endtask

  task automatic test_ignored_pulse();
    req_a = 1'b1;
    #2;
    req_a = 1'b0;
    tick();
    chk("pulse_gnt_a", gnt_a, 1'b0);
    chk("pulse_busy",  busy,  1'b0);
  endtask

  // Last grant issued was B, so the pointer favours A first.
  task automatic test_pointer();
    req_a = 1'b1; req_b = 1'b1;
    tick();
    chk("ptr_first_a", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("ptr_idle", busy, 1'b0);
    req_a = 1'b1; req_b = 1'b1;
    tick();
    chk("ptr_then_b", gnt_b, 1'b1);
    chk("ptr_then_b_sel", sel, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    logic exp_a;
    req_a = 1'b1; req_b = 1'b1;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef MUX_ARB_TIMEOUT_EN
      exp_a = ((i / HM) % 2) == 0;
`else
      exp_a = 1'b1;
`endif
      chk($sformatf("hold_gnt_a[%0d]", i), gnt_a, exp_a);
      chk($sformatf("hold_gnt_b[%0d]", i), gnt_b, ~exp_a);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

`ifdef MUX_ARB_TIMEOUT_EN
  // Sole holder at timeout keeps the grant and the counter saturates.
  task automatic test_timeout_sole();
    req_a = 1'b1; req_b = 1'b0;
    apply_reset();
    for (int i = 0; i < 300; i++) tick();
    chk("sole_gnt_a", gnt_a, 1'b1);
    req_b = 1'b1;
    tick();
    chk("sole_no_rotate_sat", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask
`endif

  task automatic test_async_reset();
    req_a = 1'b0; req_b = 1'b1;
    apply_reset();
    tick();
    chk("ar_gnt_b", gnt_b, 1'b1);
    chk("ar_sel_b", sel,   1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_drop_gnt_b", gnt_b, 1'b0);
    chk("ar_drop_busy",  busy,  1'b0);
    chk("ar_drop_sel",   sel,   1'b0);
    req_a = 1'b1; req_b = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_restart_a", gnt_a, 1'b1);
    chk("ar_restart_b", gnt_b, 1'b0);
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_ignored_pulse();
    test_pointer();
    test_hold();
`ifdef MUX_ARB_TIMEOUT_EN
    test_timeout_sole();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
